// File: rtl/usr_serdes.sv
// Universal shift register with a handshaked W-bit serializer (TX) and
// deserializer (RX). It converts between N-bit flits and narrow link lanes.
//
// Handshake rules: a TX beat transfers on a cycle where ser_out_valid and
// ser_out_ready are both high. An RX beat transfers on a cycle where
// ser_in_ready and ser_in_valid are both high. The assembled word transfers
// on a cycle where word_valid and word_ready are both high. A valid signal,
// and the data it qualifies, never changes while it waits for ready.
module usr_serdes #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   op,
  input  logic [N-1:0] I,
  input  logic         right_in,
  input  logic         left_in,
  output logic [N-1:0] A,
  output logic [W-1:0] ser_out,
  output logic         ser_out_valid,
  input  logic         ser_out_ready,
  input  logic [W-1:0] ser_in,
  input  logic         ser_in_valid,
  output logic         ser_in_ready,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         tx_done,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SHR      = 3'd1;
  localparam logic [2:0] OP_SHL      = 3'd2;
  localparam logic [2:0] OP_LOAD     = 3'd3;
  localparam logic [2:0] OP_ROR      = 3'd4;
  localparam logic [2:0] OP_ROL      = 3'd5;
  localparam logic [2:0] OP_TX_START = 3'd6;
  localparam logic [2:0] OP_RX_START = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TX     = 2'd1,
    S_RX     = 2'd2,
    S_RXDONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tx_done_nxt;

  // State, shift register, beat counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      A       <= '0;
      cnt     <= '0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      A       <= a_nxt;
      cnt     <= cnt_nxt;
      tx_done <= tx_done_nxt;
    end
  end

  // Next-state, next register value and beat counting. Ops are only
  // decoded in IDLE; in every other state op is dropped.
  always_comb begin
    state_nxt   = state;
    a_nxt       = A;
    cnt_nxt     = cnt;
    tx_done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        case (op)
          OP_NOP:  a_nxt = A;
          OP_SHR:  a_nxt = {right_in, A[N-1:1]};
          OP_SHL:  a_nxt = {A[N-2:0], left_in};
          OP_LOAD: a_nxt = I;
          OP_ROR:  a_nxt = {A[0], A[N-1:1]};
          OP_ROL:  a_nxt = {A[N-2:0], A[N-1]};
          OP_TX_START: begin
            a_nxt     = I;
            cnt_nxt   = '0;
            state_nxt = S_TX;
          end
          OP_RX_START: begin
            cnt_nxt   = '0;
            state_nxt = S_RX;
          end
          default: a_nxt = A;
        endcase
      end
      S_TX: begin
        if (ser_out_ready) begin
          a_nxt   = {A[N-W-1:0], {W{1'b0}}};
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_BEAT) begin
            cnt_nxt     = '0;
            state_nxt   = S_IDLE;
            tx_done_nxt = 1'b1;
          end
        end
      end
      S_RX: begin
        if (ser_in_valid) begin
          a_nxt   = {A[N-W-1:0], ser_in};
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = S_RXDONE;
          end
        end
      end
      S_RXDONE: begin
        if (word_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane and status outputs decoded straight from the registered state.
  always_comb begin
    ser_out       = A[N-1 -: W];
    ser_out_valid = (state == S_TX);
    ser_in_ready  = (state == S_RX);
    word_valid    = (state == S_RXDONE);
    busy          = (state != S_IDLE);
    state_dbg     = state;
  end

endmodule

// File: doc/usr_serdes.md
Name: usr_serdes

Overview:
- Parametrised universal shift register for the mesh datapath. Supports hold, parallel load, single-bit logical shift and rotate in both directions.
- Adds two handshaked modes: a W-bit-per-beat serializer (TX) and deserializer (RX), used to convert between N-bit flits and narrow W-bit link lanes.
- Sits between router port buffers and inter-node links.

Parameters:
- N, 32, register width in bits. Must be a multiple of W.
- W, 8, lane width in bits (bits per serial beat). W < N and W >= 1.
- BEATS, N/W, derived localparam: beats per word.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  command. Sampled only in IDLE. 0 NOP, 1 SHR, 2 SHL, 3 LOAD, 4 ROR, 5 ROL, 6 TX_START, 7 RX_START.
- I  input  N  parallel load data for LOAD and TX_START.
- right_in  input  1  fill bit entering the MSB on SHR.
- left_in  input  1  fill bit entering the LSB on SHL.
- A  output  N  register contents, always visible.
- ser_out  output  W  TX lane data; equals A[N-1:N-W] (MSB-first).
- ser_out_valid  output  1  high throughout TX state.
- ser_out_ready  input  1  downstream accepts a TX beat.
- ser_in  input  W  RX lane data.
- ser_in_valid  input  1  RX beat present.
- ser_in_ready  output  1  high throughout RX state.
- word_valid  output  1  high in RXDONE; A holds the assembled word.
- word_ready  input  1  consumer takes the assembled word.
- tx_done  output  1  one-cycle pulse, registered, on the cycle after the final TX beat is accepted.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - A=0, state=IDLE, beat counter=0.
  - tx_done=0, ser_out_valid=0, ser_in_ready=0, word_valid=0, busy=0.
- States: IDLE, TX, RX, RXDONE. Beat counter width is $clog2(BEATS) (minimum 1 bit).
- IDLE, one op executed per cycle, result in A at the next edge:
  - NOP: A unchanged.
  - SHR: A <= {right_in, A[N-1:1]}.
  - SHL: A <= {A[N-2:0], left_in}.
  - LOAD: A <= I.
  - ROR: A <= {A[0], A[N-1:1]}.
  - ROL: A <= {A[N-2:0], A[N-1]}.
  - TX_START: A <= I, cnt <= 0, go to TX.
  - RX_START: cnt <= 0, go to RX. A is not cleared.
- TX:
  - ser_out_valid=1.
  - Beat accepted when ser_out_valid && ser_out_ready. On accept: A <= {A[N-W-1:0], W'b0} and cnt++.
  - On the accept with cnt==BEATS-1: go to IDLE and assert tx_done on the next cycle.
  - No accept: A and cnt hold; ser_out stays stable (no data change while valid and not ready).
- RX:
  - ser_in_ready=1.
  - On ser_in_valid: A <= {A[N-W-1:0], ser_in} and cnt++. The first beat ends up in the MSBs.
  - On the beat with cnt==BEATS-1: go to RXDONE.
- RXDONE:
  - word_valid=1, ser_in_ready=0, A held.
  - When word_ready=1: go to IDLE. word_valid drops on the next cycle.
- op is ignored whenever busy=1. No queuing; the command is lost.
- Back-to-back:
  - An op issued on the cycle the FSM enters IDLE (the cycle after the last TX beat or after the word_ready handshake) is executed.
  - Minimum TX_START-to-TX_START spacing is BEATS+1 cycles when ser_out_ready stays high.
- After TX completes, A = 0 (all data shifted out).
- Reset mid-TX/RX aborts immediately. No tx_done pulse; partial data is discarded.
- The ser_in_valid/ser_out_ready inputs are don't-care outside their respective states.

Test Plan:
- Reset then idle ops, each from A=32'h80000001: SHR with right_in=1 -> A=32'hC0000000; SHL with left_in=0 -> 32'h00000002; ROR -> 32'hC0000000; ROL -> 32'h00000003.
- LOAD I=32'hDEADBEEF -> A=32'hDEADBEEF next cycle; NOP for 3 cycles -> unchanged.
- TX_START I=32'hA1B2C3D4 with ser_out_ready toggling 1,0,1,1,0,1 -> ser_out beats A1,B2,C3,D4 in order. Data is stable while stalled. tx_done pulses once after D4 is accepted; busy falls; A=0.
- RX_START, then beats 11,22,33,44 with 2-cycle gaps in ser_in_valid -> word_valid with A=32'h11223344. Hold word_ready=0 for 5 cycles -> A and word_valid stable. word_ready=1 -> IDLE.
- While in TX, drive op=LOAD, I=32'hFFFFFFFF -> ignored; serialized stream unchanged.
- Assert reset after 2 TX beats -> next cycle A=0, busy=0, ser_out_valid=0, no tx_done. A subsequent TX_START works normally.
